// File: rtl/pairing_op_loader_pkg.sv
// Shared types and status-byte encoding for the pairing core operand loader.
package pairing_op_loader_pkg;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        START  = 2'd1,
        RUN    = 2'd2,
        REPORT = 2'd3
    } state_t;

    localparam logic [3:0] STATUS_NIB = 4'hA;
    localparam int FLAG_TO  = 3;
    localparam int FLAG_FMT = 2;
    localparam int FLAG_OK  = 0;

    function automatic logic [7:0] status_byte(input logic to, input logic fmt, input logic ok);
        logic [7:0] s;
        s           = {STATUS_NIB, 4'b0000};
        s[FLAG_TO]  = to;
        s[FLAG_FMT] = fmt;
        s[FLAG_OK]  = ok;
        return s;
    endfunction

endpackage

// File: rtl/pairing_op_loader_timer.sv
// Run-phase cycle counter; tc flags the last permitted cycle (TIMEOUT-1).
module pairing_cycle_timer #(
    parameter int TIMEOUT = 2**20
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TC_VAL = TW'(TIMEOUT - 1);

    logic [TW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == TC_VAL);

endmodule

// File: rtl/pairing_op_loader.sv
// Byte-stream front end for the pairing core: loads four operands, runs the core once,
// and returns one status byte.
//
//   state  | meaning
//   LOAD   | accepting operand bytes (x1, y1, x2, y2, MSB first)
//   START  | one-cycle core_start, operands just loaded, timer cleared
//   RUN    | waiting for a rising core_done or timer terminal count
//   REPORT | status byte presented until the consumer takes it
module pairing_op_loader
    import pairing_op_loader_pkg::*;
#(
    parameter int W       = 194,
    parameter int NB      = (W + 7) / 8,
    parameter int TIMEOUT = 2**20
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] x1,
    output logic [W-1:0] y1,
    output logic [W-1:0] x2,
    output logic [W-1:0] y2,
    output logic         core_start,
    input  logic         core_done,
    input  logic         core_ok,
    output logic [7:0]   st_data,
    output logic         st_valid,
    input  logic         st_ready,
    output logic         busy
);
    localparam int OPB = 8 * NB;
    localparam int SW  = 4 * OPB;
    localparam int CW  = $clog2(4 * NB);
    localparam logic [CW-1:0]  LAST_BYTE = CW'(4 * NB - 1);
    localparam logic [OPB-1:0] OP_PAD    = {OPB{1'b1}} << W;
    localparam logic [SW-1:0]  PAD_MASK  = {4{OP_PAD}};

    state_t        state, state_n;
    // Only 99 bytes are stored; the final byte is taken straight from in_data.
    logic [SW-9:0] staging;
    logic [SW-1:0] stage_next;
    logic [CW-1:0] byte_cnt;
    logic          rdy;
    logic          done_q;
    logic          to_flag, fmt_flag, ok_flag;
    logic          accept, last_byte, pad_err, edge_seen;
    logic          tmr_clear, tmr_en, tc;

    assign stage_next = {staging, in_data};
    assign pad_err    = |(stage_next & PAD_MASK);
    assign accept     = in_valid && rdy;
    assign last_byte  = accept && (byte_cnt == LAST_BYTE);
    assign edge_seen  = core_done && !done_q;
    assign in_ready   = rdy;

    pairing_cycle_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (tmr_clear),
        .enable (tmr_en),
        .tc     (tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LOAD;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n    = state;
        core_start = 1'b0;
        busy       = 1'b1;
        st_valid   = 1'b0;
        st_data    = 8'h00;
        tmr_clear  = 1'b0;
        tmr_en     = 1'b0;
        case (state)
            LOAD: begin
                busy = 1'b0;
                if (last_byte) begin
                    state_n = pad_err ? REPORT : START;
                end
            end
            START: begin
                core_start = 1'b1;
                tmr_clear  = 1'b1;
                state_n    = RUN;
            end
            RUN: begin
                tmr_en = 1'b1;
                if (edge_seen || tc) begin
                    state_n = REPORT;
                end
            end
            REPORT: begin
                st_valid = 1'b1;
                st_data  = status_byte(to_flag, fmt_flag, ok_flag);
                if (st_ready) begin
                    state_n = LOAD;
                end
            end
            default: state_n = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            staging  <= '0;
            byte_cnt <= '0;
            rdy      <= 1'b0;
            done_q   <= 1'b0;
            to_flag  <= 1'b0;
            fmt_flag <= 1'b0;
            ok_flag  <= 1'b0;
            x1       <= '0;
            y1       <= '0;
            x2       <= '0;
            y2       <= '0;
        end else begin
            rdy <= (state_n == LOAD);
            // Tracking done through START means a done already high at entry to RUN is stale.
            done_q <= core_done;
            if (accept) begin
                staging  <= stage_next[SW-9:0];
                byte_cnt <= last_byte ? '0 : byte_cnt + 1'b1;
            end
            if (last_byte) begin
                if (pad_err) begin
                    fmt_flag <= 1'b1;
                end else begin
                    x1 <= stage_next[3*OPB +: W];
                    y1 <= stage_next[2*OPB +: W];
                    x2 <= stage_next[1*OPB +: W];
                    y2 <= stage_next[0 +: W];
                end
            end
            if (state == RUN) begin
                if (edge_seen) begin
                    ok_flag <= core_ok;
                    to_flag <= 1'b0;
                end else if (tc) begin
                    ok_flag <= 1'b0;
                    to_flag <= 1'b1;
                end
            end
            if (state == REPORT && st_ready) begin
                to_flag  <= 1'b0;
                fmt_flag <= 1'b0;
                ok_flag  <= 1'b0;
                byte_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pairing_op_loader.sv
// Bench for pairing_op_loader: random operand streams, a behavioural core with
// programmable done latency and ok, and a reference model of the status byte and timing.
module tb_pairing_op_loader;
    localparam int W       = 194;
    localparam int NB      = 25;
    localparam int TIMEOUT = 16;
    localparam int PAD     = 8 * NB - W;
    localparam int NBYTES  = 4 * NB;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [7:0]   in_data = 8'h00;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] x1, y1, x2, y2;
    logic         core_start;
    logic         core_done = 1'b0;
    logic         core_ok = 1'b0;
    logic [7:0]   st_data;
    logic         st_valid;
    logic         st_ready = 1'b0;
    logic         busy;

    int errors = 0;
    int checks = 0;

    logic [7:0]        bytes [NBYTES];
    logic [3:0][W-1:0] last_ops = '0;
    logic [W-1:0]      obs [4];

    assign obs[0] = x1;
    assign obs[1] = y1;
    assign obs[2] = x2;
    assign obs[3] = y2;

    always #5 clk = ~clk;

    pairing_op_loader #(.W(W), .NB(NB), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .x1         (x1),
        .y1         (y1),
        .x2         (x2),
        .y2         (y2),
        .core_start (core_start),
        .core_done  (core_done),
        .core_ok    (core_ok),
        .st_data    (st_data),
        .st_valid   (st_valid),
        .st_ready   (st_ready),
        .busy       (busy)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before the bench finished");
        $fatal(1);
    end

    function automatic logic [3:0][W-1:0] fixed_ops();
        logic [3:0][W-1:0] r;
        r[0] = W'(192'h6a18950064046a122a14118668466a262a91509688159890);
        r[1] = W'(192'h1d4b3c8a90f2e1577c03a9d6b2418e5f30c7a6d9124be807);
        r[2] = W'(192'h0b7e2f19a4c6d3580e91f7a23c65b0d48e1f2a7093c6d5b4);
        r[3] = W'(192'h2c95e1a07f3b46d81e2a9c05b7f3d6e1489a0c2f5e7b1d39);
        return r;
    endfunction

    function automatic logic [3:0][W-1:0] rand_ops();
        logic [3:0][W-1:0] r;
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < W; i++)
                r[k][i] = 1'($urandom_range(0, 1));
        return r;
    endfunction

    // Each operand becomes NB big-endian bytes with zero pad bits on top.
    task automatic build_bytes(input logic [3:0][W-1:0] ops);
        logic [8*NB-1:0] e;
        for (int k = 0; k < 4; k++) begin
            e = (8*NB)'(ops[k]);
            for (int b = 0; b < NB; b++)
                bytes[k*NB + b] = e[8*(NB-1-b) +: 8];
        end
    endtask

    // Called and returns on a falling edge; in_valid is randomly throttled.
    task automatic feed(input int nbytes);
        int idx = 0;
        int guard = 0;
        bit early = 1'b0;
        while (idx < nbytes && guard < 20 * NBYTES) begin
            if (busy !== 1'b0 || st_valid !== 1'b0 || core_start !== 1'b0) early = 1'b1;
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = bytes[idx];
            if (in_valid && in_ready) idx++;
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b0;
        in_data  = 8'h00;
        checks++;
        if (idx != nbytes) begin
            errors++;
            $display("FAIL feed_count: accepted %0d bytes, required %0d", idx, nbytes);
        end
        checks++;
        if (early) begin
            errors++;
            $display("FAIL feed_idle: loader busy/start/status during load, required idle until last byte");
        end
    endtask

    // rise: falling edges after the core_start cycle at which done goes high.
    task automatic do_op(input logic [3:0][W-1:0] ops, input int rise, input bit okv,
                         input bit stale, input int drop, input int stall);
        bit         exp_fmt;
        logic [7:0] exp_st;
        int         run_exp;
        int         c;
        bit         seen;
        logic [7:0] held;
        int         bad;

        exp_fmt = 1'b0;
        for (int k = 0; k < 4; k++)
            if ((bytes[k*NB] >> (8 - PAD)) != 8'h00) exp_fmt = 1'b1;
        if (exp_fmt)                exp_st = 8'hA4;
        else if (rise <= TIMEOUT)   exp_st = okv ? 8'hA1 : 8'hA0;
        else                        exp_st = 8'hA8;
        run_exp = (rise <= TIMEOUT) ? rise : TIMEOUT;

        core_done = stale;
        core_ok   = 1'($urandom_range(0, 1));
        feed(NBYTES);

        if (exp_fmt) begin
            checks++;
            if (core_start !== 1'b0 || st_valid !== 1'b1) begin
                errors++;
                $display("FAIL fmt_report: core_start=%b st_valid=%b, required 0 and 1", core_start, st_valid);
            end
        end else begin
            checks++;
            if (core_start !== 1'b1 || st_valid !== 1'b0) begin
                errors++;
                $display("FAIL start_pulse: core_start=%b st_valid=%b after last byte, required 1 and 0", core_start, st_valid);
            end
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (obs[k] !== ops[k]) begin
                    errors++;
                    $display("FAIL operand%0d: got %h required %h", k, obs[k], ops[k]);
                end
            end
            last_ops = ops;
            c    = 0;
            seen = 1'b0;
            while (!seen && c < TIMEOUT + 8) begin
                if (stale && c == drop) core_done = 1'b0;
                if (c == rise) begin
                    core_done = 1'b1;
                    core_ok   = okv;
                end else begin
                    core_ok = 1'($urandom_range(0, 1));
                end
                in_valid = 1'($urandom_range(0, 1));
                in_data  = 8'($urandom);
                @(negedge clk);
                c++;
                if (c == 1) begin
                    checks++;
                    if (core_start !== 1'b0) begin
                        errors++;
                        $display("FAIL start_width: core_start=%b in second cycle, required 0", core_start);
                    end
                end
                if (st_valid === 1'b1) seen = 1'b1;
            end
            checks++;
            if (!seen || c != run_exp + 1) begin
                errors++;
                $display("FAIL report_latency: seen=%0d after %0d run cycles, required %0d", seen, c - 1, run_exp);
            end
        end

        checks++;
        if (st_data !== exp_st) begin
            errors++;
            $display("FAIL status: got %h required %h", st_data, exp_st);
        end
        held = st_data;
        bad  = 0;
        for (int i = 0; i < stall; i++) begin
            st_ready = 1'b0;
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 8'($urandom);
            @(negedge clk);
            if (st_valid !== 1'b1 || st_data !== held || in_ready !== 1'b0 || core_start !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL status_hold: %0d unstable cycles while stalled, required 0", bad);
        end
        st_ready = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        st_ready = 1'b0;
        checks++;
        if (st_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || st_data !== 8'h00) begin
            errors++;
            $display("FAIL after_transfer: st_valid=%b in_ready=%b busy=%b st_data=%h, required 0 1 0 00",
                     st_valid, in_ready, busy, st_data);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (obs[k] !== last_ops[k]) begin
                errors++;
                $display("FAIL operand_hold%0d: got %h required %h", k, obs[k], last_ops[k]);
            end
        end
        core_done = 1'b0;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h5a;
        st_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({in_ready, core_start, st_valid, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: in_ready/core_start/st_valid/busy=%b, required 0000",
                     {in_ready, core_start, st_valid, busy});
        end
        checks++;
        if (st_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_status: st_data=%h, required 00", st_data);
        end
        checks++;
        if ({x1, y1, x2, y2} !== '0) begin
            errors++;
            $display("FAIL reset_operands: operands not zero during reset");
        end
        reset    = 1'b0;
        in_valid = 1'b0;
        st_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b busy=%b, required 1 0", in_ready, busy);
        end
    endtask

    task automatic test_success();
        logic [3:0][W-1:0] ops;
        ops = fixed_ops();
        build_bytes(ops);
        do_op(ops, $urandom_range(1, TIMEOUT), 1'b1, 1'b0, 0, 0);
    endtask

    task automatic test_check_fail();
        logic [3:0][W-1:0] ops;
        ops = fixed_ops();
        build_bytes(ops);
        do_op(ops, $urandom_range(1, TIMEOUT), 1'b0, 1'b0, 0, 2);
    endtask

    task automatic test_timeout();
        logic [3:0][W-1:0] ops;
        ops = rand_ops();
        build_bytes(ops);
        do_op(ops, 1000, 1'b1, 1'b0, 0, 1);
    endtask

    task automatic test_fmt_error();
        logic [3:0][W-1:0] ops;
        ops = fixed_ops();
        build_bytes(ops);
        bytes[3*NB] = 8'h04;
        do_op(ops, 3, 1'b1, 1'b0, 0, 3);
    endtask

    task automatic test_stale_done();
        logic [3:0][W-1:0] ops;
        int d;
        ops = rand_ops();
        build_bytes(ops);
        d = $urandom_range(1, 4);
        do_op(ops, d + $urandom_range(1, TIMEOUT - d), 1'($urandom_range(0, 1)), 1'b1, d, 10);
    endtask

    task automatic test_timeout_boundary();
        logic [3:0][W-1:0] ops;
        ops = rand_ops();
        build_bytes(ops);
        do_op(ops, TIMEOUT, 1'b1, 1'b0, 0, 0);
        ops = rand_ops();
        build_bytes(ops);
        do_op(ops, TIMEOUT + 1, 1'b1, 1'b0, 0, 0);
    endtask

    task automatic test_reset_mid_load();
        logic [3:0][W-1:0] ops;
        ops = rand_ops();
        build_bytes(ops);
        feed(37);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({in_ready, busy, st_valid, core_start} !== 4'b0000) begin
            errors++;
            $display("FAIL midload_reset: in_ready/busy/st_valid/core_start=%b, required 0000",
                     {in_ready, busy, st_valid, core_start});
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || st_valid !== 1'b0) begin
            errors++;
            $display("FAIL midload_release: in_ready=%b st_valid=%b, required 1 0", in_ready, st_valid);
        end
        ops = rand_ops();
        build_bytes(ops);
        do_op(ops, $urandom_range(1, TIMEOUT), 1'b1, 1'b0, 0, 0);
    endtask

    task automatic test_back_to_back();
        logic [3:0][W-1:0] ops;
        int k, d, r;
        bit st;
        for (int n = 0; n < 8; n++) begin
            ops = rand_ops();
            build_bytes(ops);
            if ($urandom_range(0, 3) == 0) begin
                k = $urandom_range(0, 3);
                bytes[k*NB] = bytes[k*NB] | (8'h01 << (8 - PAD + $urandom_range(0, PAD - 1)));
            end
            st = 1'($urandom_range(0, 1));
            d  = $urandom_range(1, 3);
            r  = $urandom_range(d + 1, TIMEOUT + 4);
            do_op(ops, r, 1'($urandom_range(0, 1)), st, d, $urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset();
        test_success();
        test_check_fail();
        test_timeout();
        test_fmt_error();
        test_stale_done();
        test_timeout_boundary();
        test_reset_mid_load();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
